// File: rtl/fabric_user_top.sv
// Pad-side 8-bit counter plus two independent 36-bit arithmetic channels (west/east),
// each producing registered sum, difference and bitwise AND one cycle after operand sample.
module fabric_user_top (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  io_in,
  output logic [9:0]  io_out,
  output logic [9:0]  io_oeb,
  input  logic [35:0] W_OPA,
  input  logic [35:0] W_OPB,
  input  logic [35:0] E_OPA,
  input  logic [35:0] E_OPB,
  output logic [35:0] W_RES0,
  output logic [35:0] W_RES1,
  output logic [35:0] W_RES2,
  output logic [35:0] E_RES0,
  output logic [35:0] E_RES1,
  output logic [35:0] E_RES2
);

  typedef struct packed {
    logic [35:0] res0;
    logic [35:0] res1;
    logic [35:0] res2;
  } side_res_t;

  function automatic side_res_t side_calc(input logic [35:0] opa, input logic [35:0] opb);
    side_res_t r;
    r.res0 = opa + opb;
    r.res1 = opa - opb;
    r.res2 = opa & opb;
    return r;
  endfunction

  logic [7:0] ctr_q, ctr_d;
  side_res_t  w_res_q, w_res_d;
  side_res_t  e_res_q, e_res_d;

  // Pad bits 9:2 are inputs with no function.
  logic unused_io_in;
  assign unused_io_in = ^io_in[9:2];

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    ctr_d = ctr_q;
    if (io_in[0]) begin
      ctr_d = '0;
    end else if (io_in[1]) begin
      ctr_d = ctr_q + 8'd1;
    end
    w_res_d = side_calc(W_OPA, W_OPB);
    e_res_d = side_calc(E_OPA, E_OPB);
  end

  // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr_q   <= '0;
      w_res_q <= '0;
      e_res_q <= '0;
    end else begin
      ctr_q   <= ctr_d;
      w_res_q <= w_res_d;
      e_res_q <= e_res_d;
    end
  end

  assign io_out = {ctr_q, 2'b00};
  // Pad direction is fixed: bits 1:0 are inputs, bits 9:2 are driven.
  assign io_oeb = 10'b00_0000_0011;

  assign W_RES0 = w_res_q.res0;
  assign W_RES1 = w_res_q.res1;
  assign W_RES2 = w_res_q.res2;
  assign E_RES0 = e_res_q.res0;
  assign E_RES1 = e_res_q.res1;
  assign E_RES2 = e_res_q.res2;

endmodule

// File: tb/tb_fabric_user_top.sv
// Self-checking bench for fabric_user_top: vector table for the counter, directed operand
// cases, counter wrap, and a randomized run against a behavioural model with a mid-stream reset.
module tb_fabric_user_top;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  io_in;
  logic [9:0]  io_out;
  logic [9:0]  io_oeb;
  logic [35:0] w_opa, w_opb, e_opa, e_opb;
  logic [35:0] w_res0, w_res1, w_res2, e_res0, e_res1, e_res2;

  always #5 clk = ~clk;

  fabric_user_top dut (
    .clk    (clk),
    .rst    (rst),
    .io_in  (io_in),
    .io_out (io_out),
    .io_oeb (io_oeb),
    .W_OPA  (w_opa),
    .W_OPB  (w_opb),
    .E_OPA  (e_opa),
    .E_OPB  (e_opb),
    .W_RES0 (w_res0),
    .W_RES1 (w_res1),
    .W_RES2 (w_res2),
    .E_RES0 (e_res0),
    .E_RES1 (e_res1),
    .E_RES2 (e_res2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  localparam longint unsigned MOD36 = 64'h10_0000_0000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint unsigned ref_add(input longint unsigned a, input longint unsigned b);
    return (a + b) % MOD36;
  endfunction

  function automatic longint unsigned ref_sub(input longint unsigned a, input longint unsigned b);
    return (a + MOD36 - b) % MOD36;
  endfunction

  function automatic logic [35:0] rand36();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[35:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare every output against the counter value and the operands sampled at the last edge.
  task automatic check_all(input string tag, input int exp_ctr,
                           input longint unsigned wa, input longint unsigned wb,
                           input longint unsigned ea, input longint unsigned eb);
    check({tag, " io_out"}, 64'(io_out), 64'((exp_ctr * 4) % 1024));
    check({tag, " io_oeb"}, 64'(io_oeb), 64'h003);
    check({tag, " W_RES0"}, 64'(w_res0), ref_add(wa, wb));
    check({tag, " W_RES1"}, 64'(w_res1), ref_sub(wa, wb));
    check({tag, " W_RES2"}, 64'(w_res2), wa & wb);
    check({tag, " E_RES0"}, 64'(e_res0), ref_add(ea, eb));
    check({tag, " E_RES1"}, 64'(e_res1), ref_sub(ea, eb));
    check({tag, " E_RES2"}, 64'(e_res2), ea & eb);
  endtask

  task automatic check_reset_state(input string tag);
    check_all(tag, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic [9:0] io_in;
    logic [9:0] exp_out;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int mctr;
    logic [35:0] wa, wb, ea, eb;

    // io_in applied for one edge, then io_out expected after that edge.
    for (int i = 0; i < 5; i++) vecs[i] = '{10'h003, 10'h000};
    vecs[5]  = '{10'h002, 10'h004};
    vecs[6]  = '{10'h002, 10'h008};
    vecs[7]  = '{10'h002, 10'h00C};
    vecs[8]  = '{10'h002, 10'h010};
    vecs[9]  = '{10'h000, 10'h010};
    vecs[10] = '{10'h000, 10'h010};
    vecs[11] = '{10'h3FC, 10'h010};
    vecs[12] = '{10'h001, 10'h000};
    vecs[13] = '{10'h3FE, 10'h004};
    vecs[14] = '{10'h003, 10'h000};
    vecs[15] = '{10'h002, 10'h004};
    vecs[16] = '{10'h3FD, 10'h000};
    vecs[17] = '{10'h000, 10'h000};

    // Reset from time zero with nonzero operands: outputs must be zero before any edge.
    rst   = 1'b1;
    io_in = 10'h002;
    w_opa = 36'h123456789; w_opb = 36'h0F0F0F0F0;
    e_opa = 36'hFEDCBA987; e_opb = 36'h111111111;
    #2;
    check_reset_state("reset_t0");
    rst = 1'b0;
    io_in = 10'h000;
    w_opa = '0; w_opb = '0; e_opa = '0; e_opb = '0;
    #1;

    // Counter vector table.
    foreach (vecs[i]) begin
      io_in = vecs[i].io_in;
      tick();
      check($sformatf("vec%0d io_out", i), 64'(io_out), 64'(vecs[i].exp_out));
    end

    // Directed west case, then east case with west operands held.
    io_in = 10'h000;
    w_opa = 36'hFFFFFFFFF; w_opb = 36'h555555555;
    tick();
    check("west RES0", 64'(w_res0), 64'h555555554);
    check("west RES1", 64'(w_res1), 64'hAAAAAAAAA);
    check("west RES2", 64'(w_res2), 64'h555555555);
    e_opa = 36'h000000001; e_opb = 36'hAAAAAAAAA;
    tick();
    check("east RES0", 64'(e_res0), 64'hAAAAAAAAB);
    check("east RES1", 64'(e_res1), 64'h555555557);
    check("east RES2", 64'(e_res2), 64'h000000000);
    check("west hold RES0", 64'(w_res0), 64'h555555554);
    check("west hold RES1", 64'(w_res1), 64'hAAAAAAAAA);
    check("west hold RES2", 64'(w_res2), 64'h555555555);

    // Full wrap: clear, then 256 enabled edges return to zero.
    io_in = 10'h001;
    tick();
    check("wrap clear", 64'(io_out), 64'h000);
    io_in = 10'h002;
    for (int i = 1; i <= 256; i++) begin
      tick();
      check($sformatf("wrap step%0d", i), 64'(io_out), 64'(((i % 256) * 4)));
    end
    check("wrap final", 64'(io_out), 64'h000);

    // Randomized run against the behavioural model, with an asynchronous reset mid-stream.
    io_in = 10'h001;
    tick();
    mctr = 0;
    for (int i = 0; i < 300; i++) begin
      io_in    = 10'($urandom());
      io_in[0] = ($urandom_range(0, 7) == 0);
      wa = rand36(); wb = rand36(); ea = rand36(); eb = rand36();
      if (i % 37 == 0) begin
        wb = wa; eb = 36'hFFFFFFFFF;
      end
      w_opa = wa; w_opb = wb; e_opa = ea; e_opb = eb;
      tick();
      if (io_in[0]) mctr = 0;
      else if (io_in[1]) mctr = (mctr + 1) % 256;
      check_all($sformatf("rand%0d", i), mctr, wa, wb, ea, eb);
      if (i == 150) begin
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("rand mid reset");
        rst = 1'b0;
        mctr = 0;
        #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
